dac_channel_scheduler: RTL and testbench

Shares the 4-channel onboard SPI DAC (channels A-D) between four independent requesters. Coalesces per-channel updates, picks the next channel round-robin, and builds the 32-bit DAC frames. Each frame is handed to the existing SPI frame shifter through a start/busy handshake. After reset it runs an init sequence that loads every channel with a known code.

---
 rtl/dac_pkg.sv | 27 ++
 rtl/dac_rr_arbiter.sv | 35 +++
 rtl/dac_channel_scheduler.sv | 117 +++++++++++
 tb/tb_dac_channel_scheduler.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// Shared definitions for the DAC channel scheduler: command codes, sizes,
// FSM encoding and the frame builder used by the issue logic.
package dac_pkg;

   localparam int N_CH    = 4;
   localparam int FRAME_W = 32;

   localparam logic [3:0] WR_N         = 4'b0000;
   localparam logic [3:0] WR_UPD_N     = 4'b0011;
   localparam logic [3:0] WR_N_UPD_ALL = 4'b0010;

   typedef enum logic [2:0] {
      ST_INIT_ISSUE = 3'd0,
      ST_IDLE       = 3'd1,
      ST_ISSUE      = 3'd2,
      ST_WAIT_BUSY  = 3'd3,
      ST_WAIT_DONE  = 3'd4,
      ST_GAP        = 3'd5
   } state_t;

   function automatic logic [FRAME_W-1:0] build_frame(input logic [3:0]  cmd,
                                                      input logic [3:0]  addr,
                                                      input logic [11:0] data);
      return {8'h00, cmd, addr, data, 4'h0};
   endfunction

endpackage

// File: rtl/dac_rr_arbiter.sv
// Combinational round-robin pick: first requesting channel after ptr,
// wrapping so that ptr itself has the lowest priority.
module dac_rr_arbiter
   import dac_pkg::*;
(
   input  logic [N_CH-1:0] req,
   input  logic [1:0]      ptr,
   output logic [N_CH-1:0] grant,
   output logic [1:0]      grant_idx,
   output logic            any_req,
   output logic            any_other
);

   logic [1:0] idx;
   logic       found;

   always_comb begin
      grant     = '0;
      grant_idx = 2'd0;
      found     = 1'b0;
      idx       = 2'd0;
      for (int k = 1; k <= N_CH; k++) begin
         idx = ptr + 2'(k);
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant_idx  = idx;
            grant[idx] = 1'b1;
         end
      end
   end

   assign any_req   = |req;
   assign any_other = |(req & ~grant);

endmodule

// File: rtl/dac_channel_scheduler.sv
// Shares the 4-channel SPI DAC between four requesters: coalesces updates,
// arbitrates round-robin and hands 32-bit frames to the SPI shifter.
module dac_channel_scheduler
   import dac_pkg::*;
#(
   parameter int          DATA_W     = 12,
   parameter logic [11:0] INIT_CODE  = 12'h800,
   parameter int          GAP_CYCLES = 2
)(
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N_CH-1:0]        req_valid,
   input  logic [N_CH*DATA_W-1:0] req_data,
   output logic [N_CH-1:0]        req_ready,
   input  logic                   sync_mode,
   output logic [FRAME_W-1:0]     tx_frame,
   output logic                   tx_start,
   input  logic                   tx_busy,
   output logic                   init_done,
   output logic                   busy
);

   state_t            state;
   logic [N_CH-1:0]   pend;
   logic [DATA_W-1:0] pend_data [N_CH];
   logic [1:0]        rr_ptr;
   logic [2:0]        init_cnt;
   logic [3:0]        gap_cnt;

   logic [N_CH-1:0]   grant;
   logic [1:0]        grant_idx;
   logic              any_req;
   logic              any_other;
   logic [N_CH-1:0]   accept;
   logic              dispatch;
   logic              gap_last;
   logic [3:0]        issue_cmd;

   dac_rr_arbiter u_arb (
      .req       (pend),
      .ptr       (rr_ptr),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any_req   (any_req),
      .any_other (any_other)
   );

   assign req_ready = {N_CH{init_done}};
   assign busy      = (state != ST_IDLE);
   assign accept    = req_valid & req_ready;
   assign dispatch  = (state == ST_IDLE) && !tx_busy && any_req;
   assign gap_last  = (gap_cnt == 4'(GAP_CYCLES - 1));
   assign issue_cmd = !sync_mode ? WR_UPD_N : (any_other ? WR_N : WR_N_UPD_ALL);

   // A new accept wins over the dispatch clear, so a value arriving while its
   // channel is being sent is kept for a later frame.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend <= '0;
         for (int i = 0; i < N_CH; i++) pend_data[i] <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++)
            if (accept[i]) pend_data[i] <= req_data[i*DATA_W +: DATA_W];
         pend <= (pend & ~(dispatch ? grant : '0)) | accept;
      end
   end

   // Frame and start are registered on entry to ISSUE/INIT_ISSUE so tx_start is
   // high exactly in those states. Reset parks in the last GAP cycle so the
   // first init frame follows the same path as every later one.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_GAP;
         gap_cnt   <= 4'(GAP_CYCLES - 1);
         init_cnt  <= 3'd0;
         init_done <= 1'b0;
         rr_ptr    <= 2'd3;
         tx_frame  <= '0;
         tx_start  <= 1'b0;
      end else begin
         tx_start <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (dispatch) begin
                  tx_frame <= build_frame(issue_cmd, {2'b00, grant_idx}, pend_data[grant_idx]);
                  tx_start <= 1'b1;
                  rr_ptr   <= grant_idx;
                  state    <= ST_ISSUE;
               end
            end
            ST_ISSUE, ST_INIT_ISSUE: state <= ST_WAIT_BUSY;
            ST_WAIT_BUSY: if (tx_busy) state <= ST_WAIT_DONE;
            ST_WAIT_DONE: begin
               if (!tx_busy) begin
                  gap_cnt <= 4'd0;
                  state   <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (!gap_last) begin
                  gap_cnt <= gap_cnt + 4'd1;
               end else if (init_cnt == 3'd4) begin
                  init_done <= 1'b1;
                  state     <= ST_IDLE;
               end else begin
                  tx_frame <= build_frame(WR_UPD_N, {2'b00, init_cnt[1:0]}, INIT_CODE);
                  tx_start <= 1'b1;
                  init_cnt <= init_cnt + 3'd1;
                  state    <= ST_INIT_ISSUE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dac_channel_scheduler.sv
// Directed bench for dac_channel_scheduler with a simple SPI shifter model
// that stays busy for a fixed number of cycles after each tx_start.
module tb_dac_channel_scheduler;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req_valid;
   logic [47:0] req_data;
   logic [3:0]  req_ready;
   logic        sync_mode;
   logic [31:0] tx_frame;
   logic        tx_start;
   logic        tx_busy;
   logic        init_done;
   logic        busy;

   logic [3:0]  sh_cnt;
   logic [31:0] frames [$];
   int          cyc = 0;
   int          start_cyc = 0;
   int          t0;
   int          errors = 0;
   int          checks = 0;

   dac_channel_scheduler dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .sync_mode (sync_mode),
      .tx_frame  (tx_frame),
      .tx_start  (tx_start),
      .tx_busy   (tx_busy),
      .init_done (init_done),
      .busy      (busy)
   );

   always #10 clk = ~clk;

   // Shifter model: busy from the cycle after tx_start for 8 cycles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)              sh_cnt <= 4'd0;
      else if (tx_start)      sh_cnt <= 4'd8;
      else if (sh_cnt != 4'd0) sh_cnt <= sh_cnt - 4'd1;
   end
   assign tx_busy = (sh_cnt != 4'd0);

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!reset && tx_start) begin
         frames.push_back(tx_frame);
         start_cyc = cyc;
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed timeout required finish");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Called at a negedge; holds the request for one cycle.
   task automatic applyStimulus(input logic [3:0] valid, input logic [47:0] data);
      req_valid = valid;
      req_data  = data;
      @(negedge clk);
      req_valid = 4'h0;
   endtask

   task automatic popFrame(input string tag, input logic [31:0] expected);
      if (frames.size() == 0) checkOutput(tag, 32'hFFFF_FFFF, expected);
      else                    checkOutput(tag, frames.pop_front(), expected);
   endtask

   task automatic waitStart();
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (tx_start) return;
      end
      checkOutput("start_timeout", 32'd0, 32'd1);
   endtask

   task automatic waitQuiet();
      int quiet = 0;
      for (int i = 0; i < 400 && quiet < 3; i++) begin
         @(negedge clk);
         quiet = busy ? 0 : quiet + 1;
      end
      if (quiet < 3) checkOutput("quiet_timeout", 32'd0, 32'd1);
   endtask

   task automatic waitInit();
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (init_done) return;
      end
      checkOutput("init_timeout", 32'd0, 32'd1);
   endtask

   task automatic checkInitFrames();
      popFrame("init_a", 32'h0030_8000);
      popFrame("init_b", 32'h0031_8000);
      popFrame("init_c", 32'h0032_8000);
      popFrame("init_d", 32'h0033_8000);
   endtask

   initial begin
      reset     = 1'b1;
      req_valid = 4'h0;
      req_data  = '0;
      sync_mode = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_ready",  32'(req_ready), 32'h0);
      checkOutput("rst_frame",  tx_frame,       32'h0);
      checkOutput("rst_start",  32'(tx_start),  32'h0);
      checkOutput("rst_init",   32'(init_done), 32'h0);
      checkOutput("rst_busy",   32'(busy),      32'h1);
      reset = 1'b0;

      waitInit();
      checkInitFrames();
      checkOutput("init_done",  32'(init_done), 32'h1);
      checkOutput("init_ready", 32'(req_ready), 32'hF);
      waitQuiet();

      // Batch of four in sync mode: only the last write updates all outputs.
      sync_mode = 1'b1;
      applyStimulus(4'hF, {12'h004, 12'h003, 12'h002, 12'h001});
      waitQuiet();
      popFrame("sync_ch0", 32'h0000_0010);
      popFrame("sync_ch1", 32'h0001_0020);
      popFrame("sync_ch2", 32'h0002_0030);
      popFrame("sync_ch3", 32'h0023_0040);
      checkOutput("sync_extra", 32'(frames.size()), 32'd0);
      sync_mode = 1'b0;

      t0 = cyc;
      applyStimulus(4'b0100, {12'h000, 12'hB00, 24'h0});
      waitQuiet();
      popFrame("single_ch2", 32'h0032_B000);
      checkOutput("single_latency", 32'(start_cyc - t0), 32'd2);

      // Three writes to channel 1 while channel 0 is on the wire coalesce.
      applyStimulus(4'b0001, {36'h0, 12'h5A5});
      waitStart();
      applyStimulus(4'b0010, {24'h0, 12'h111, 12'h0});
      applyStimulus(4'b0010, {24'h0, 12'h222, 12'h0});
      applyStimulus(4'b0010, {24'h0, 12'h333, 12'h0});
      waitQuiet();
      popFrame("coal_ch0", 32'h0030_5A50);
      popFrame("coal_ch1", 32'h0031_3330);
      checkOutput("coal_extra", 32'(frames.size()), 32'd0);

      // Channel 0 re-requested in its own ISSUE cycle, with channels 1 and 2.
      applyStimulus(4'b0001, {36'h0, 12'h0A1});
      waitStart();
      applyStimulus(4'b0111, {12'h000, 12'h0C3, 12'h0E5, 12'h0B2});
      waitQuiet();
      popFrame("rereq_old0", 32'h0030_0A10);
      popFrame("rereq_ch1",  32'h0031_0E50);
      popFrame("rereq_ch2",  32'h0032_0C30);
      popFrame("rereq_new0", 32'h0030_0B20);
      checkOutput("rereq_extra", 32'(frames.size()), 32'd0);

      // Reset while the shifter is busy, with channel 1 still pending.
      applyStimulus(4'b0001, {36'h0, 12'h777});
      waitStart();
      repeat (3) @(negedge clk);
      applyStimulus(4'b0010, {24'h0, 12'h123, 12'h0});
      checkOutput("mid_txbusy", 32'(tx_busy), 32'h1);
      reset = 1'b1;
      #1;
      checkOutput("mid_start", 32'(tx_start),  32'h0);
      checkOutput("mid_init",  32'(init_done), 32'h0);
      checkOutput("mid_ready", 32'(req_ready), 32'h0);
      checkOutput("mid_busy",  32'(busy),      32'h1);
      checkOutput("mid_frame", tx_frame,       32'h0);
      frames.delete();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      waitInit();
      checkInitFrames();
      repeat (40) @(negedge clk);
      checkOutput("mid_no_pend", 32'(frames.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
